// File: rtl/data_break_arbiter_pkg.sv
// ============================================================================
// Module : sd_types (package)
// Brief  : Shared CPU major-state codes and the data-break arbiter FSM type.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sd_types;

  // CPU major-state codes as presented on the 5-bit state bus
  localparam logic [4:0] c_st_fetch = 5'd0;
  localparam logic [4:0] c_st_defer = 5'd1;
  localparam logic [4:0] c_st_exec  = 5'd2;
  localparam logic [4:0] c_st_db1   = 5'd3;
  localparam logic [4:0] c_st_db2   = 5'd4;

  // Data-break arbiter control states
  typedef enum logic [1:0] {
    DB_IDLE  = 2'd0,
    DB_BREAK = 2'd1,
    DB_HOLD  = 2'd2
  } db_state_t;

endpackage : sd_types

`default_nettype wire

// File: rtl/data_break_arbiter_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin picker. The search starts at the
//          requester after last_grant and wraps, so the most recent winner
//          has lowest priority.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [IW-1:0]   winner,
  output logic            valid
);

  logic [IW-1:0] w_cand;

  // Walk candidates last_grant+1 .. last_grant+NREQ (mod NREQ); first hit wins
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    w_cand = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_cand = IW'((int'(last_grant) + i) % NREQ);
      if (!valid && req[w_cand]) begin
        valid  = 1'b1;
        winner = w_cand;
      end
    end
  end

endmodule : rr_pick

`default_nettype wire

// File: rtl/data_break_arbiter.sv
// ============================================================================
// Module : data_break_arbiter
// Brief  : Arbitrates several data-break requesters onto the single CPU
//          data-break port. One transfer at a time; the winner's address,
//          data and direction are frozen for the whole break, which ends on
//          DB2 (done) or on a wait timeout (err), followed by one HOLD clock.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_break_arbiter
  import sd_types::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [4:0]            state,
  input  logic                  break_in_prog,
  input  logic [11:0]           dmaDIN,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0][14:0] req_addr,
  input  logic [NREQ-1:0]       req_wr,
  input  logic [NREQ-1:0][11:0] req_data,
  output logic [NREQ-1:0]       done,
  output logic [NREQ-1:0]       err,
  output logic [11:0]           rd_data,
  output logic                  data_break,
  output logic                  to_disk,
  output logic [14:0]           dmaAddr,
  output logic [11:0]           dmaDOUT
);

  localparam int         c_iw      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] c_timeout = 8'(TIMEOUT);

  db_state_t       r_state;
  logic [c_iw-1:0] r_last;
  logic [c_iw-1:0] r_win;
  logic [7:0]      r_cnt;
  logic [c_iw-1:0] w_win;
  logic            w_valid;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (c_iw)
  ) u_rr_pick (
    .req        (req),
    .last_grant (r_last),
    .winner     (w_win),
    .valid      (w_valid)
  );

  // Arbitration FSM with registered CPU-side and requester-side outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= DB_IDLE;
      r_last     <= c_iw'(NREQ - 1);
      r_win      <= '0;
      r_cnt      <= '0;
      done       <= '0;
      err        <= '0;
      rd_data    <= '0;
      data_break <= 1'b0;
      to_disk    <= 1'b0;
      dmaAddr    <= '0;
      dmaDOUT    <= '0;
    end else if (clear) begin
      r_state    <= DB_IDLE;
      r_last     <= c_iw'(NREQ - 1);
      r_win      <= '0;
      r_cnt      <= '0;
      done       <= '0;
      err        <= '0;
      rd_data    <= '0;
      data_break <= 1'b0;
      to_disk    <= 1'b0;
      dmaAddr    <= '0;
      dmaDOUT    <= '0;
    end else begin
      // completion / abort strobes last exactly one clock
      done <= '0;
      err  <= '0;
      case (r_state)
        DB_IDLE: begin
          if (w_valid) begin
            r_win      <= w_win;
            dmaAddr    <= req_addr[w_win];
            dmaDOUT    <= req_data[w_win];
            to_disk    <= ~req_wr[w_win];
            data_break <= 1'b1;
            r_cnt      <= '0;
            r_state    <= DB_BREAK;
          end
        end
        DB_BREAK: begin
          // DB2 is checked first so it wins over a coincident timeout
          if (state == c_st_db2) begin
            rd_data     <= dmaDIN;
            data_break  <= 1'b0;
            done[r_win] <= 1'b1;
            r_last      <= r_win;
            r_state     <= DB_HOLD;
          end else if (!break_in_prog) begin
            // a break already under way in the CPU freezes the wait count
            if (r_cnt == c_timeout) begin
              data_break <= 1'b0;
              err[r_win] <= 1'b1;
              r_last     <= r_win;
              r_state    <= DB_HOLD;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        DB_HOLD: begin
          r_cnt   <= '0;
          r_state <= DB_IDLE;
        end
        default: begin
          r_state <= DB_IDLE;
        end
      endcase
    end
  end

endmodule : data_break_arbiter

`default_nettype wire

// File: tb/tb_data_break_arbiter.sv
// ============================================================================
// Module : tb_data_break_arbiter
// Brief  : Directed self-checking bench for data_break_arbiter (NREQ=2,
//          TIMEOUT=8): vector table of single transfers plus hand-written
//          contention, timeout, stall, clear and async-reset sequences.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_break_arbiter;
  import sd_types::*;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            clear = 1'b0;
  logic [4:0]      state = c_st_fetch;
  logic            break_in_prog = 1'b0;
  logic [11:0]     dmaDIN = '0;
  logic [1:0]      req = '0;
  logic [1:0][14:0] req_addr = '0;
  logic [1:0]      req_wr = '0;
  logic [1:0][11:0] req_data = '0;
  logic [1:0]      done;
  logic [1:0]      err;
  logic [11:0]     rd_data;
  logic            data_break;
  logic            to_disk;
  logic [14:0]     dmaAddr;
  logic [11:0]     dmaDOUT;

  int total = 0;
  int bad   = 0;

  data_break_arbiter #(
    .NREQ    (2),
    .TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .state         (state),
    .break_in_prog (break_in_prog),
    .dmaDIN        (dmaDIN),
    .req           (req),
    .req_addr      (req_addr),
    .req_wr        (req_wr),
    .req_data      (req_data),
    .done          (done),
    .err           (err),
    .rd_data       (rd_data),
    .data_break    (data_break),
    .to_disk       (to_disk),
    .dmaAddr       (dmaAddr),
    .dmaDOUT       (dmaDOUT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0o want %0o", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  wr;
    logic [14:0] a0, a1;
    logic [11:0] d0, d1;
    logic [11:0] din;
    int          dly;
    bit          drop;
    logic [14:0] e_addr;
    logic [11:0] e_dout;
    logic        e_td;
    logic [1:0]  e_done;
  } vec_t;

  vec_t vt[6];

  initial begin
    // req   wr     a0       a1       d0       d1       din      dly drop  e_addr   e_dout   td    e_done
    vt[0] = '{2'b01, 2'b01, 15'o01234, 15'o05555, 12'o7070, 12'o1111, 12'o0000, 3, 1'b0, 15'o01234, 12'o7070, 1'b0, 2'b01};
    vt[1] = '{2'b10, 2'b00, 15'o00000, 15'o02222, 12'o0000, 12'o0000, 12'o4321, 2, 1'b0, 15'o02222, 12'o0000, 1'b1, 2'b10};
    vt[2] = '{2'b11, 2'b10, 15'o03333, 15'o04444, 12'o0123, 12'o0456, 12'o0777, 1, 1'b0, 15'o03333, 12'o0123, 1'b1, 2'b01};
    vt[3] = '{2'b11, 2'b10, 15'o03333, 15'o04444, 12'o0123, 12'o0456, 12'o1357, 1, 1'b0, 15'o04444, 12'o0456, 1'b0, 2'b10};
    vt[4] = '{2'b01, 2'b01, 15'o07777, 15'o00000, 12'o7777, 12'o0000, 12'o1234, 4, 1'b1, 15'o07777, 12'o7777, 1'b0, 2'b01};
    vt[5] = '{2'b01, 2'b00, 15'o00001, 15'o00000, 12'o0001, 12'o0000, 12'o6543, 0, 1'b0, 15'o00001, 12'o0001, 1'b1, 2'b01};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit seen;

    // ---------------- reset state ----------------
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_db",   data_break, 0);
    chk("rst_td",   to_disk, 0);
    chk("rst_addr", dmaAddr, 0);
    chk("rst_dout", dmaDOUT, 0);
    chk("rst_rd",   rd_data, 0);
    chk("rst_done", done, 0);
    chk("rst_err",  err, 0);

    // ---------------- vector table ----------------
    for (int i = 0; i < 6; i++) begin
      req_wr   = vt[i].wr;
      req_addr = {vt[i].a1, vt[i].a0};
      req_data = {vt[i].d1, vt[i].d0};
      req      = vt[i].req;
      @(negedge clk);
      chk($sformatf("v%0d_db", i),   data_break, 1);
      chk($sformatf("v%0d_addr", i), dmaAddr, vt[i].e_addr);
      chk($sformatf("v%0d_dout", i), dmaDOUT, vt[i].e_dout);
      chk($sformatf("v%0d_td", i),   to_disk, vt[i].e_td);
      // disturb requester side; the break must stay frozen
      req_addr = ~req_addr;
      req_data = ~req_data;
      req_wr   = ~req_wr;
      if (vt[i].drop) req = '0;
      repeat (vt[i].dly) @(negedge clk);
      chk($sformatf("v%0d_frz_addr", i), dmaAddr, vt[i].e_addr);
      chk($sformatf("v%0d_frz_td", i),   to_disk, vt[i].e_td);
      state  = c_st_db2;
      dmaDIN = vt[i].din;
      @(negedge clk);
      state = c_st_fetch;
      chk($sformatf("v%0d_done", i), done, vt[i].e_done);
      chk($sformatf("v%0d_rd", i),   rd_data, vt[i].din);
      chk($sformatf("v%0d_dbl", i),  data_break, 0);
      chk($sformatf("v%0d_err", i),  err, 0);
      req = '0;
      @(negedge clk);
      chk($sformatf("v%0d_done_end", i), done, 0);
      @(negedge clk);
    end

    // ---------------- contention: alternating grants ----------------
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    req_wr   = 2'b11;
    req_addr = {15'o02222, 15'o01111};
    req_data = {12'o2222, 12'o1111};
    req      = 2'b11;
    @(negedge clk);
    chk("cont_lat", data_break, 1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("cont%0d_addr", k), dmaAddr, (k % 2) ? 15'o02222 : 15'o01111);
      state = c_st_db2;
      @(negedge clk);
      state = c_st_fetch;
      chk($sformatf("cont%0d_done", k), done, (k % 2) ? 2'b10 : 2'b01);
      if (k == 3) begin
        req = '0;
      end else begin
        @(negedge clk);
        chk($sformatf("cont%0d_gap", k), data_break, 0);
        @(negedge clk);
        chk($sformatf("cont%0d_next", k), data_break, 1);
      end
    end
    repeat (2) @(negedge clk);

    // ---------------- timeout abort ----------------
    req_wr   = 2'b01;
    req_addr = {15'o0, 15'o00777};
    req      = 2'b01;
    @(negedge clk);
    chk("to_db", data_break, 1);
    n = 0;
    seen = 1'b0;
    while (err == 2'b00 && n < 40) begin
      @(negedge clk);
      n++;
      if (done != 2'b00) seen = 1'b1;
    end
    chk("to_err",   err, 2'b01);
    chk("to_clks",  n, 9);
    chk("to_nodone", seen, 0);
    chk("to_dbl",   data_break, 0);
    @(negedge clk);
    chk("to_err_end", err, 0);
    chk("to_idle_db", data_break, 0);
    @(negedge clk);
    chk("to_rearb", data_break, 1);
    state = c_st_db2;
    @(negedge clk);
    state = c_st_fetch;
    req = '0;
    repeat (2) @(negedge clk);

    // ---------------- stall: break in progress past TIMEOUT ----------------
    req = 2'b01;
    @(negedge clk);
    chk("st_db", data_break, 1);
    break_in_prog = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (err != 2'b00) seen = 1'b1;
    end
    chk("st_noerr", seen, 0);
    chk("st_held",  data_break, 1);
    state = c_st_db2;
    @(negedge clk);
    state = c_st_fetch;
    break_in_prog = 1'b0;
    chk("st_done", done, 2'b01);
    req = '0;
    repeat (2) @(negedge clk);

    // ---------------- synchronous clear mid-break ----------------
    req = 2'b01;
    @(negedge clk);
    chk("clr_db", data_break, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    req = '0;
    chk("clr_dbl",  data_break, 0);
    chk("clr_addr", dmaAddr, 0);
    chk("clr_done", done, 0);
    chk("clr_err",  err, 0);
    repeat (2) @(negedge clk);

    // ---------------- async reset mid-break ----------------
    req_addr = {15'o06666, 15'o05432};
    req      = 2'b10;
    @(negedge clk);
    chk("ar_db", data_break, 1);
    req = 2'b11;
    #2 reset = 1'b1;
    #1;
    chk("ar_dbl",  data_break, 0);
    chk("ar_addr", dmaAddr, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("ar_done0", done, 0);
    chk("ar_err0",  err, 0);
    chk("ar_regrant", data_break, 1);
    chk("ar_win0", dmaAddr, 15'o05432);
    state = c_st_db2;
    @(negedge clk);
    state = c_st_fetch;
    chk("ar_done", done, 2'b01);
    req = '0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_data_break_arbiter

`default_nettype wire

// File: doc/data_break_arbiter.md
DATA_BREAK_ARBITER -- requirements
Module: data_break_arbiter

Interface
REQ-001 Parameter NREQ, default 2: number of data-break requesters (2..4).
REQ-002 Parameter TIMEOUT, default 255: clocks allowed between data_break assertion and CPU DB2 before abort.
REQ-003 clk  input  1  system clock; all state changes on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 clear  input  1  synchronous IOCLR; same effect as reset, sampled on clk.
REQ-006 state  input  5  CPU major state; DB2 code comes from the shared parameters.
REQ-007 break_in_prog  input  1  CPU is executing a data break cycle.
REQ-008 dmaDIN  input  12  memory read data from the CPU during DB2.
REQ-009 req  input  NREQ  per-requester break request, level, held until done.
REQ-010 req_addr  input  NREQ x 15  per-requester 15-bit memory address.
REQ-011 req_wr  input  NREQ  per-requester direction: 1 = device-to-memory write.
REQ-012 req_data  input  NREQ x 12  per-requester write data.
REQ-013 done  output  NREQ  one-clock completion pulse to the granted requester.
REQ-014 err  output  NREQ  one-clock timeout-abort pulse to the granted requester.
REQ-015 rd_data  output  12  data captured from dmaDIN; valid while done is high.
REQ-016 data_break  output  1  break request to the CPU.
REQ-017 to_disk  output  1  direction to the CPU: 1 = memory-to-device read.
REQ-018 dmaAddr  output  15  registered break address to the CPU.
REQ-019 dmaDOUT  output  12  registered write data to the CPU.

Function
REQ-020 The FSM SHALL have three states: IDLE, BREAK, HOLD.
REQ-021 IDLE: if any req is high, SHALL select a winner round-robin, starting at (last_grant+1) mod NREQ; next clock enters BREAK with data_break=1, dmaAddr/dmaDOUT/to_disk (= ~req_wr) loaded from the winner.
REQ-022 Latency from req rising in IDLE to data_break high SHALL be exactly one clock.
REQ-023 BREAK: the winner, address, data and direction SHALL be frozen; later changes on req_* are ignored.
REQ-024 BREAK with state==DB2: SHALL capture dmaDIN into rd_data, drop data_break, pulse done[winner] the next clock, update last_grant, and enter HOLD.
REQ-025 HOLD: one clock, SHALL enter IDLE, giving the requester one cycle to drop or reissue req before rearbitration.
REQ-026 BREAK SHALL use an 8-bit wait counter cleared on entry; when it reaches TIMEOUT with no DB2 and break_in_prog low: drop data_break, pulse err[winner], update last_grant, enter HOLD.
REQ-027 If break_in_prog is high, the timeout counter SHALL hold, so an in-progress break is never aborted.
REQ-028 A req dropped by the winner during BREAK SHALL NOT abort the cycle; done still pulses.
REQ-029 done and err SHALL never both be high, and at most one bit of each SHALL be high at a time.
REQ-030 Simultaneous DB2 and timeout expiry SHALL resolve as DB2 (done).
REQ-031 With NREQ=1, round-robin degenerates to always granting requester 0.

Reset
REQ-032 reset (async) or clear (sync) SHALL force IDLE, data_break=0, to_disk=0, dmaAddr=0, dmaDOUT=0, rd_data=0, done=0, err=0, counter=0, last_grant=NREQ-1 (requester 0 wins first).
REQ-033 Reset or clear mid-BREAK SHALL abandon the cycle without pulsing done or err.

Structure
REQ-034 The FSM state enum SHALL be a typedef in the shared sd_types package, next to the sd state types; the DB2 code SHALL stay in the shared parameters.
REQ-035 The round-robin winner selection SHALL be one combinational sub-module, rr_pick (inputs req, last_grant; output winner index plus valid).

Verification
REQ-036 Single request: req[0]=1, addr=15'o01234, wr=1, data=12'o7070; DB2 after 3 clocks -> data_break high 1 clock after req; dmaAddr=01234, dmaDOUT=7070, to_disk=0; done[0] pulses once.
REQ-037 Contention: req=2'b11 held continuously after reset -> grants alternate 0,1,0,1; each done precedes the next data_break by exactly the one HOLD clock.
REQ-038 Read: req[1], wr=0; dmaDIN=12'o4321 at DB2 -> to_disk=1; rd_data=4321 with done[1].
REQ-039 Timeout: TIMEOUT=8, no DB2, break_in_prog=0 -> err[0] pulses once, done stays 0, data_break drops, FSM back in IDLE 1 clock later.
REQ-040 Stall: break_in_prog=1 past TIMEOUT, then DB2 -> no err; done pulses.
REQ-041 Reset mid-BREAK: async reset asserted -> data_break=0 immediately; after release, no done or err pulses; the next grant goes to requester 0.
